// File: rtl/sevenseg_scan_if.sv
// Display-side bundle for sevenseg_scan: value/load/enable in, segment and
// anode pins plus status out.
interface sevenseg_scan_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  scan_done;
    logic                  busy;

    modport master (
        output enable, load, value,
        input  seg, an, scan_done, busy
    );

    modport slave (
        input  enable, load, value,
        output seg, an, scan_done, busy
    );
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex seven-segment driver with a double-buffered value.
// Define SEVENSEG_SCAN_LZB_EN to blank leading zero digits.
module sevenseg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    sevenseg_scan_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int NSLOT = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [4*DIGITS-1:0]   pending_reg;
    logic [4*DIGITS-1:0]   display_reg;
    logic                  busy_reg;
    logic                  scan_done_reg;
    logic [6:0]            seg_reg;
    logic [DIGITS-1:0]     an_reg;

    logic [3:0]            nib      [NSLOT];
    logic [NSLOT-1:0]      blank;
    logic                  slot_end;
    logic                  frame_end;
    logic                  boundary;

    // Unused index slots (non-power-of-two DIGITS) read as dark digits.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_digit
            if (gi < DIGITS) begin : g_real
                assign nib[gi] = display_reg[4*gi +: 4];
`ifdef SEVENSEG_SCAN_LZB_EN
                if (gi > 0) begin : g_lzb
                    assign blank[gi] = (display_reg[4*DIGITS-1:4*gi] == '0);
                end else begin : g_first
                    assign blank[gi] = 1'b0;
                end
`else
                assign blank[gi] = 1'b0;
`endif
            end else begin : g_pad
                assign nib[gi]   = 4'h0;
                assign blank[gi] = 1'b1;
            end
        end
    endgenerate

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h7E;  4'h1: glyph = 7'h30;
            4'h2: glyph = 7'h6D;  4'h3: glyph = 7'h79;
            4'h4: glyph = 7'h33;  4'h5: glyph = 7'h5B;
            4'h6: glyph = 7'h5F;  4'h7: glyph = 7'h70;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h7B;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h1F;
            4'hC: glyph = 7'h4E;  4'hD: glyph = 7'h3D;
            4'hE: glyph = 7'h4F;  default: glyph = 7'h47;
        endcase
    endfunction

    assign slot_end  = (cnt_reg == CNT_TC);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);
    // Pending may only reach the display when no frame is being drawn.
    assign boundary  = !bus.enable || frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            idx_reg       <= '0;
            pending_reg   <= '0;
            display_reg   <= '0;
            busy_reg      <= 1'b0;
            scan_done_reg <= 1'b0;
            seg_reg       <= 7'h00;
            an_reg        <= '1;
        end else begin
            if (bus.load)
                pending_reg <= bus.value;

            if (boundary) begin
                display_reg <= pending_reg;
                busy_reg    <= bus.load;
            end else if (bus.load) begin
                busy_reg    <= 1'b1;
            end

            if (!bus.enable) begin
                cnt_reg       <= '0;
                idx_reg       <= '0;
                scan_done_reg <= 1'b0;
                seg_reg       <= 7'h00;
                an_reg        <= '1;
            end else begin
                scan_done_reg <= frame_end;
                if (blank[idx_reg]) begin
                    seg_reg <= 7'h00;
                    an_reg  <= '1;
                end else begin
                    seg_reg <= glyph(nib[idx_reg]);
                    an_reg  <= ~(DIGITS'(1) << idx_reg);
                end
                if (slot_end) begin
                    cnt_reg <= '0;
                    idx_reg <= frame_end ? '0 : idx_reg + IDX_W'(1);
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign bus.seg       = seg_reg;
    assign bus.an        = an_reg;
    assign bus.scan_done = scan_done_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Time-multiplexed driver for DIGITS hex seven-segment digits. Generalises the single-digit hex decoder to N digits.
- Holds a double-buffered display value and scans the digits at a programmable refresh rate.
- Drives one shared segment bus plus per-digit anode selects.
- Sits between the CPU debug/PC outputs and the board display pins.

Parameters:
- DIGITS, 4: number of hex digits scanned. Range 1..8.
- REFRESH_DIV, 50000: clk cycles each digit is lit. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  1 = scan and drive display; 0 = blank all digits
- load  input  1  single-cycle strobe; capture value into the pending buffer
- value  input  4*DIGITS  nibble k (bits 4k+3:4k) is shown on digit k; digit 0 is rightmost
- seg  output  7  active-high segments, bit6=a … bit0=g
- an  output  DIGITS  active-low digit select, at most one bit low
- scan_done  output  1  one-cycle pulse when the last digit's slot ends
- busy  output  1  pending buffer holds a value not yet shown

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - seg=7'h00, an=all ones, scan_done=0, busy=0.
  - Refresh counter=0, digit index=0, pending=0, display=0.
- Registered outputs: seg and an are registered, one cycle after the index/display change.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 while enable=1.
  - At terminal count it wraps to 0 and the index advances.
  - Index wraps DIGITS-1 -> 0.
  - At that wrap, scan_done pulses for exactly one cycle (the cycle after the terminal count).
- Segment glyphs (seg hex), matching the existing decoder:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Double buffering:
  - load=1 writes value into pending and sets busy=1 on the next edge.
  - Pending is copied into display only at a frame boundary (index wrap DIGITS-1 -> 0), and busy clears on that same edge. This prevents tearing within a frame.
  - A load on the same cycle as the boundary copy: the new value goes to pending and busy stays 1. The old pending is copied to display.
  - Back-to-back loads: the last one wins.
- enable=0:
  - Counter and index are held at 0.
  - an=all ones and seg=00 on the next edge.
  - scan_done=0.
  - Any pending value copies to display immediately and busy clears.
- enable rising: scan restarts at digit 0 with a full REFRESH_DIV slot.
- DIGITS=1: index stays 0, an stays 0 while enabled, and scan_done pulses every REFRESH_DIV cycles.
- Reset mid-scan: all state returns to reset values asynchronously, and the pending value is lost.

Optional Feature:
- Macro: SEVENSEG_SCAN_LZB_EN.
- With the macro defined, leading-zero blanking applies:
  - A digit k > 0 is blanked (seg=00, its an bit stays 1) when it and every more-significant nibble of display are zero.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - Blanking is evaluated on display, not pending.
- Without the macro, all DIGITS digits always show their glyph, including leading zeros.

Test Plan (DIGITS=4, REFRESH_DIV=4):
- Reset: rst_n low mid-scan -> immediately seg=00, an=4'b1111, busy=0. After release with enable=1, the first slot shows an=4'b1110, seg=7E.
- Scan order: load value=16'h1234, then wait for the frame boundary. Over 16 cycles, expect (an=1110, seg=33), (1101, 79), (1011, 6D), (0111, 30), 4 cycles each. scan_done pulses once per 16 cycles, one cycle after the 0111 slot ends.
- Double buffer: load 16'hABCD mid-frame -> busy=1 and the current frame is unchanged. The next frame shows 3D, 4E, 1F, 77 and busy=0 at the wrap.
- Collision: load 16'h0F0F on the boundary cycle while pending=16'h1111 -> the next frame shows 1111 and busy stays 1. The following frame shows 0F0F.
- Enable gating: drop enable mid-slot -> next edge an=1111, seg=00, scan_done silent. On re-enable, the digit 0 slot lasts a full 4 cycles.
- SEVENSEG_SCAN_LZB_EN defined, load 16'h0040 -> digits 3 and 2 dark, digit 1 seg=33, digit 0 seg=7E. Load 16'h0000 -> only digit 0 lit, seg=7E.
